// File: rtl/nes_pkg.sv
// nes_pkg: shared definitions for the NES/SNES controller receiver.
//   - nes_state_e : receiver FSM states
//   - BTN_*       : bit positions of each button in the received word
//   - NES_*       : default timing/width constants (25 MHz pixel clock)
//   - nes_pad_t / nes_to_pad : maps a raw NES button word onto the
//     input-controller signal names used by the top level
package nes_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SETTLE,
      ST_CLK_HIGH,
      ST_CLK_LOW,
      ST_DONE
   } nes_state_e;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   localparam int NES_NUM_BITS     = 8;
   localparam int NES_LATCH_CYCLES = 300;  // 12 us at 25 MHz
   localparam int NES_HALF_PERIOD  = 75;   // 3 us at 25 MHz

   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
      logic attack;
      logic jump;
      logic select;
      logic start;
   } nes_pad_t;

   function automatic nes_pad_t nes_to_pad(input logic [7:0] b);
      nes_pad_t p;
      p.up     = b[BTN_UP];
      p.down   = b[BTN_DOWN];
      p.left   = b[BTN_LEFT];
      p.right  = b[BTN_RIGHT];
      p.attack = b[BTN_A];
      p.jump   = b[BTN_B];
      p.select = b[BTN_SELECT];
      p.start  = b[BTN_START];
      return p;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic 1-bit two-flop synchroniser for asynchronous pins.
// Ports:
//   clk   in  destination clock
//   rst_n in  synchronous active-low reset (both flops load RESET_VAL)
//   d     in  asynchronous input
//   q     out synchronised output, two clk cycles of latency
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/nes_receiver.sv
// nes_receiver: polls an NES (8-bit) or SNES (16-bit) serial controller once
// per poll request and presents an active-high, registered button word.
// Ports:
//   clk         in  system (pixel) clock
//   rst_n       in  synchronous active-low reset
//   poll        in  start request, only honoured in IDLE
//   nes_data_in in  controller serial data, asynchronous, active-low
//   nes_latch   out controller latch, registered
//   nes_clk     out controller shift clock, registered, idles low
//   buttons     out last completed button word, 1 = pressed
//   valid       out one-cycle pulse when buttons updates
//   busy        out high whenever the FSM is not in IDLE
module nes_receiver
   import nes_pkg::*;
#(
   parameter int NUM_BITS     = NES_NUM_BITS,
   parameter int LATCH_CYCLES = NES_LATCH_CYCLES,
   parameter int HALF_PERIOD  = NES_HALF_PERIOD
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                poll,
   input  logic                nes_data_in,
   output logic                nes_latch,
   output logic                nes_clk,
   output logic [NUM_BITS-1:0] buttons,
   output logic                valid,
   output logic                busy
);

   localparam int TMAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int IW   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

   localparam logic [TW-1:0] LATCH_LOAD = TW'(LATCH_CYCLES - 1);
   localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_PERIOD - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_BITS - 1);

   nes_state_e          state_q, state_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [IW-1:0]       bit_idx_q, bit_idx_d;
   logic [NUM_BITS-1:0] shift_q, shift_d;
   logic [NUM_BITS-1:0] buttons_q, buttons_d;
   logic                valid_q, valid_d;
   logic                latch_q, latch_d;
   logic                nclk_q, nclk_d;
   logic                busy_q, busy_d;

   logic                data_sync;
   logic                timer_done;
   logic [NUM_BITS-1:0] word_w;

   // Line idles high (released) so the synchroniser resets to 1.
   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync_data (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (nes_data_in),
      .q     (data_sync)
   );

   assign timer_done = (timer_q == '0);

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      buttons_d = buttons_q;
      valid_d   = 1'b0;

      // Partial word with the current bit folded in (inverted: low = pressed).
      word_w            = shift_q;
      word_w[bit_idx_q] = ~data_sync;

      case (state_q)
         ST_IDLE: begin
            if (poll) begin
               state_d   = ST_LATCH;
               timer_d   = LATCH_LOAD;
               bit_idx_d = '0;
               shift_d   = '0;
            end
         end

         ST_LATCH: begin
            if (timer_done) begin
               state_d = ST_SETTLE;
               timer_d = HALF_LOAD;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         ST_SETTLE: begin
            if (timer_done) begin
               shift_d = word_w;
               if (NUM_BITS == 1) begin
                  state_d   = ST_DONE;
                  buttons_d = word_w;
                  valid_d   = 1'b1;
               end else begin
                  state_d   = ST_CLK_HIGH;
                  timer_d   = HALF_LOAD;
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         ST_CLK_HIGH: begin
            if (timer_done) begin
               state_d = ST_CLK_LOW;
               timer_d = HALF_LOAD;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         ST_CLK_LOW: begin
            if (timer_done) begin
               shift_d = word_w;
               if (bit_idx_q == LAST_IDX) begin
                  state_d   = ST_DONE;
                  buttons_d = word_w;
                  valid_d   = 1'b1;
               end else begin
                  state_d   = ST_CLK_HIGH;
                  timer_d   = HALF_LOAD;
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Output flops are decoded from the next state so they change on the
      // same edge as the state register; buttons/valid load on the edge
      // entering DONE so both are visible during the DONE cycle.
      latch_d = (state_d == ST_LATCH);
      nclk_d  = (state_d == ST_CLK_HIGH);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         buttons_q <= '0;
         valid_q   <= 1'b0;
         latch_q   <= 1'b0;
         nclk_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         buttons_q <= buttons_d;
         valid_q   <= valid_d;
         latch_q   <= latch_d;
         nclk_q    <= nclk_d;
         busy_q    <= busy_d;
      end
   end

   assign nes_latch = latch_q;
   assign nes_clk   = nclk_q;
   assign buttons   = buttons_q;
   assign valid     = valid_q;
   assign busy      = busy_q;

endmodule
